// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared types and defaults for the quantum scheduler
package sched_pkg;

    localparam int ADDR_W       = 32;
    localparam int DEF_NUM_PROC = 4;
    localparam int DEF_QUANTUM  = 100;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        RESTORE,
        RUN,
        SAVE
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin next-valid slot finder
module rr_picker #(
    parameter int NUM_PROC = 4,
    parameter int PROC_W   = $clog2(NUM_PROC)
) (
    input  logic [NUM_PROC-1:0] valid,  // runnable slots
    input  logic [PROC_W-1:0]   cur,    // slot that ran last
    output logic [PROC_W-1:0]   nxt,    // first valid slot after cur
    output logic                found   // some slot is valid
);

    logic [PROC_W-1:0] idx;

    // Walk from the farthest candidate (cur itself) back to cur+1 so the
    // nearest valid slot after cur is the last one written.
    always_comb begin
        nxt   = cur;
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_PROC; i >= 1; i--) begin
            idx = cur + PROC_W'(i);
            if (valid[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/quantum_scheduler.sv
// rtl/quantum_scheduler.sv - preemptive round-robin PC scheduler with per-slot table
module quantum_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_PROC = DEF_NUM_PROC,
    parameter int QUANTUM  = DEF_QUANTUM,
    parameter int PROC_W   = $clog2(NUM_PROC)
) (
    input  logic              Clock,         // rising-edge clock
    input  logic              Reset,         // async active-low reset
    input  logic              Enable,        // preemption enable
    input  logic              carregando,    // memory load in progress
    input  logic              Instr_retire,  // one instruction retired
    input  logic              Halt,          // running process halted
    input  logic [ADDR_W-1:0] PC_atual,      // current PC
    input  logic              Reg_valid,     // register process strobe
    input  logic [PROC_W-1:0] Reg_id,        // slot being registered
    input  logic [ADDR_W-1:0] Reg_base,      // base of registered process
    output logic [ADDR_W-1:0] PC_entrada,    // PC to load
    output logic              Ativa_PC,      // PC load strobe
    output logic [ADDR_W-1:0] Offset,        // base of running process
    output logic [PROC_W-1:0] Proc_atual,    // running slot
    output logic              Quantum_end,   // pulse in SAVE
    output logic              Troca,         // pulse with Ativa_PC
    output logic              Ocioso         // nothing runnable
);

    localparam int CNT_W = $clog2(QUANTUM + 1);
    localparam logic [CNT_W-1:0] QLOAD = CNT_W'(QUANTUM);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   base_tab [NUM_PROC];
    logic [ADDR_W-1:0]   pc_tab   [NUM_PROC];
    logic [NUM_PROC-1:0] valid;
    logic [CNT_W-1:0]    cnt;
    logic [PROC_W-1:0]   nxt_q;
    logic                halt_q;
    logic [ADDR_W-1:0]   pc_ent_q;
    logic [ADDR_W-1:0]   off_q;
    logic [PROC_W-1:0]   pick_nxt;
    logic                pick_found;
    logic                dec;
    logic                expire;
    logic                reg_ok;

    rr_picker #(
        .NUM_PROC(NUM_PROC),
        .PROC_W  (PROC_W)
    ) u_picker (
        .valid(valid),
        .cur  (Proc_atual),
        .nxt  (pick_nxt),
        .found(pick_found)
    );

    assign dec    = (state == RUN) && Instr_retire && !carregando && Enable && (cnt != '0);
    assign expire = dec && (cnt == CNT_W'(1));
    // The running slot cannot be rewritten while its context is live.
    assign reg_ok = Reg_valid && !((Reg_id == Proc_atual) && ((state == RUN) || (state == SAVE)));

    always_comb begin
        state_nxt   = state;
        Ativa_PC    = 1'b0;
        Troca       = 1'b0;
        Quantum_end = 1'b0;
        Ocioso      = 1'b0;
        PC_entrada  = pc_ent_q;
        Offset      = off_q;
        case (state)
            IDLE: begin
                Ocioso = 1'b1;
                if ((|valid) || Reg_valid) state_nxt = SELECT;
            end
            SELECT: begin
                if (pick_found) begin
                    state_nxt = RESTORE;
                end else begin
                    state_nxt = IDLE;
                    Ocioso    = 1'b1;
                end
            end
            RESTORE: begin
                PC_entrada = pc_tab[nxt_q];
                Offset     = base_tab[nxt_q];
                if (!carregando) begin
                    Ativa_PC  = 1'b1;
                    Troca     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (Halt || expire) state_nxt = SAVE;
            end
            SAVE: begin
                Quantum_end = 1'b1;
                state_nxt   = SELECT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            valid      <= '0;
            cnt        <= '0;
            Proc_atual <= '0;
            nxt_q      <= '0;
            halt_q     <= 1'b0;
            pc_ent_q   <= '0;
            off_q      <= '0;
            for (int i = 0; i < NUM_PROC; i++) begin
                base_tab[i] <= '0;
                pc_tab[i]   <= '0;
            end
        end else begin
            state <= state_nxt;
            if (reg_ok) begin
                base_tab[Reg_id] <= Reg_base;
                pc_tab[Reg_id]   <= Reg_base;
                valid[Reg_id]    <= 1'b1;
            end
            case (state)
                SELECT: nxt_q <= pick_nxt;
                RESTORE: begin
                    if (!carregando) begin
                        Proc_atual <= nxt_q;
                        cnt        <= QLOAD;
                        pc_ent_q   <= pc_tab[nxt_q];
                        off_q      <= base_tab[nxt_q];
                    end
                end
                RUN: begin
                    if (dec) cnt <= cnt - 1'b1;
                    // Halt wins over a coincident expiry.
                    halt_q <= Halt;
                end
                SAVE: begin
                    if (halt_q) valid[Proc_atual] <= 1'b0;
                    else        pc_tab[Proc_atual] <= PC_atual;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_quantum_scheduler.sv
// tb/tb_quantum_scheduler.sv - directed self-checking bench for quantum_scheduler
module tb_quantum_scheduler;

    logic        Clock;
    logic        Reset;
    logic        Enable;
    logic        carregando;
    logic        Instr_retire;
    logic        Halt;
    logic [31:0] PC_atual;
    logic        Reg_valid;
    logic [1:0]  Reg_id;
    logic [31:0] Reg_base;
    logic [31:0] PC_entrada;
    logic        Ativa_PC;
    logic [31:0] Offset;
    logic [1:0]  Proc_atual;
    logic        Quantum_end;
    logic        Troca;
    logic        Ocioso;

    int n_chk  = 0;
    int n_fail = 0;

    quantum_scheduler #(
        .NUM_PROC(4),
        .QUANTUM (3)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Enable      (Enable),
        .carregando  (carregando),
        .Instr_retire(Instr_retire),
        .Halt        (Halt),
        .PC_atual    (PC_atual),
        .Reg_valid   (Reg_valid),
        .Reg_id      (Reg_id),
        .Reg_base    (Reg_base),
        .PC_entrada  (PC_entrada),
        .Ativa_PC    (Ativa_PC),
        .Offset      (Offset),
        .Proc_atual  (Proc_atual),
        .Quantum_end (Quantum_end),
        .Troca       (Troca),
        .Ocioso      (Ocioso)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic        rv;
        logic [1:0]  rid;
        logic [31:0] rbase;
        logic        ret;
        logic        hlt;
        logic [31:0] pca;
        logic        e_ativa;
        logic        e_qend;
        logic        e_oci;
        logic [1:0]  e_proc;
        logic [31:0] e_pc;
        logic [31:0] e_off;
    } vec_t;

    vec_t vecs [29];

    function automatic vec_t mk(input logic rv, input logic [1:0] rid, input logic [31:0] rb,
                                input logic ret, input logic hlt, input logic [31:0] pca,
                                input logic ea, input logic eq, input logic eo,
                                input logic [1:0] ep, input logic [31:0] epc, input logic [31:0] eoff);
        vec_t v;
        v.rv = rv; v.rid = rid; v.rbase = rb; v.ret = ret; v.hlt = hlt; v.pca = pca;
        v.e_ativa = ea; v.e_qend = eq; v.e_oci = eo; v.e_proc = ep; v.e_pc = epc; v.e_off = eoff;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic rv, input logic [1:0] rid, input logic [31:0] rb,
                       input logic ret, input logic hlt, input logic car, input logic en,
                       input logic [31:0] pca);
        @(negedge Clock);
        Reg_valid    = rv;
        Reg_id       = rid;
        Reg_base     = rb;
        Instr_retire = ret;
        Halt         = hlt;
        carregando   = car;
        Enable       = en;
        PC_atual     = pca;
        #1;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    endtask

    initial begin
        // rv rid base ret hlt pca | ativa qend oci proc pc off
        vecs[0]  = mk(1, 0, 0,   0, 0, 0,     0, 0, 1, 0, 0,     0);
        vecs[1]  = mk(1, 2, 200, 0, 0, 0,     0, 0, 0, 0, 0,     0);
        vecs[2]  = mk(0, 0, 0,   0, 0, 0,     1, 0, 0, 0, 0,     0);
        vecs[3]  = mk(0, 0, 0,   1, 0, 'h2A,  0, 0, 0, 0, 0,     0);
        vecs[4]  = mk(0, 0, 0,   1, 0, 'h2A,  0, 0, 0, 0, 0,     0);
        vecs[5]  = mk(0, 0, 0,   1, 0, 'h2A,  0, 0, 0, 0, 0,     0);
        vecs[6]  = mk(0, 0, 0,   0, 0, 'h2A,  0, 1, 0, 0, 0,     0);
        vecs[7]  = mk(0, 0, 0,   0, 0, 0,     0, 0, 0, 0, 0,     0);
        vecs[8]  = mk(0, 0, 0,   0, 0, 0,     1, 0, 0, 0, 200,   200);
        vecs[9]  = mk(0, 0, 0,   1, 0, 'h77,  0, 0, 0, 2, 0,     200);
        vecs[10] = mk(0, 0, 0,   1, 0, 'h77,  0, 0, 0, 2, 0,     200);
        vecs[11] = mk(0, 0, 0,   1, 0, 'h77,  0, 0, 0, 2, 0,     200);
        vecs[12] = mk(0, 0, 0,   0, 0, 'h77,  0, 1, 0, 2, 0,     200);
        vecs[13] = mk(0, 0, 0,   0, 0, 0,     0, 0, 0, 2, 0,     200);
        vecs[14] = mk(0, 0, 0,   0, 0, 0,     1, 0, 0, 2, 'h2A,  0);
        vecs[15] = mk(0, 0, 0,   1, 0, 'h30,  0, 0, 0, 0, 0,     0);
        vecs[16] = mk(0, 0, 0,   1, 0, 'h30,  0, 0, 0, 0, 0,     0);
        vecs[17] = mk(0, 0, 0,   1, 0, 'h30,  0, 0, 0, 0, 0,     0);
        vecs[18] = mk(0, 0, 0,   0, 0, 'h30,  0, 1, 0, 0, 0,     0);
        vecs[19] = mk(0, 0, 0,   0, 0, 0,     0, 0, 0, 0, 0,     0);
        vecs[20] = mk(0, 0, 0,   0, 0, 0,     1, 0, 0, 0, 'h77,  200);
        vecs[21] = mk(0, 0, 0,   0, 1, 0,     0, 0, 0, 2, 0,     200);
        vecs[22] = mk(0, 0, 0,   0, 0, 0,     0, 1, 0, 2, 0,     200);
        vecs[23] = mk(0, 0, 0,   0, 0, 0,     0, 0, 0, 2, 0,     200);
        vecs[24] = mk(0, 0, 0,   0, 0, 0,     1, 0, 0, 2, 'h30,  0);
        vecs[25] = mk(0, 0, 0,   0, 1, 0,     0, 0, 0, 0, 0,     0);
        vecs[26] = mk(0, 0, 0,   0, 0, 0,     0, 1, 0, 0, 0,     0);
        vecs[27] = mk(0, 0, 0,   0, 0, 0,     0, 0, 1, 0, 0,     0);
        vecs[28] = mk(0, 0, 0,   0, 0, 0,     0, 0, 1, 0, 0,     0);

        Reset = 1'b0; Enable = 1'b1; carregando = 1'b0; Instr_retire = 1'b0; Halt = 1'b0;
        PC_atual = '0; Reg_valid = 1'b0; Reg_id = '0; Reg_base = '0;
        repeat (3) @(negedge Clock);
        #1;
        chk("rst_ocioso", Ocioso, 1);
        chk("rst_ativa", Ativa_PC, 0);
        chk("rst_troca", Troca, 0);
        chk("rst_qend", Quantum_end, 0);
        chk("rst_offset", Offset, 0);
        chk("rst_pc_entrada", PC_entrada, 0);
        chk("rst_proc", Proc_atual, 0);
        @(negedge Clock);
        Reset = 1'b1;

        // Round-robin, preemption, saved-PC restore and halt handling.
        for (int i = 0; i < 29; i++) begin
            cyc(vecs[i].rv, vecs[i].rid, vecs[i].rbase, vecs[i].ret, vecs[i].hlt, 1'b0, 1'b1, vecs[i].pca);
            chk($sformatf("v%0d_ativa", i), Ativa_PC, vecs[i].e_ativa);
            chk($sformatf("v%0d_troca", i), Troca, vecs[i].e_ativa);
            chk($sformatf("v%0d_qend", i), Quantum_end, vecs[i].e_qend);
            chk($sformatf("v%0d_ocioso", i), Ocioso, vecs[i].e_oci);
            chk($sformatf("v%0d_proc", i), Proc_atual, vecs[i].e_proc);
            chk($sformatf("v%0d_offset", i), Offset, vecs[i].e_off);
            if (vecs[i].e_ativa)
                chk($sformatf("v%0d_pc_entrada", i), PC_entrada, vecs[i].e_pc);
        end

        // carregando stalls the restore and the quantum counter.
        cyc(1, 2'd1, 32'h100, 0, 0, 1, 1, 0);
        cyc(0, 2'd0, 0, 0, 0, 1, 1, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 2'd0, 0, 0, 0, 1, 1, 0);
            chk($sformatf("load_hold%0d_ativa", k), Ativa_PC, 0);
            chk($sformatf("load_hold%0d_troca", k), Troca, 0);
        end
        cyc(0, 2'd0, 0, 0, 0, 0, 1, 0);
        chk("load_rel_ativa", Ativa_PC, 1);
        chk("load_rel_pc", PC_entrada, 32'h100);
        chk("load_rel_off", Offset, 32'h100);
        for (int k = 0; k < 4; k++) begin
            // First cycle also tries to overwrite the running slot; must be ignored.
            cyc(k == 0, 2'd1, 32'h999, 1, 0, 1, 1, 0);
            chk($sformatf("load_run%0d_qend", k), Quantum_end, 0);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(0, 2'd0, 0, 1, 0, 0, 1, 0);
            chk($sformatf("cnt%0d_qend", k), Quantum_end, 0);
        end
        cyc(0, 2'd0, 0, 0, 0, 0, 1, 32'h150);
        chk("solo_save_qend", Quantum_end, 1);
        chk("solo_save_proc", Proc_atual, 1);
        idle_cyc();
        chk("solo_sel_ocioso", Ocioso, 0);
        idle_cyc();
        chk("solo_ativa", Ativa_PC, 1);
        chk("solo_troca", Troca, 1);
        chk("solo_pc", PC_entrada, 32'h150);
        chk("solo_off", Offset, 32'h100);

        // Enable=0 freezes the quantum; halt still switches.
        for (int k = 0; k < 10; k++) begin
            cyc(k == 0, 2'd3, 32'h300, 1, 0, 0, 0, 0);
            chk($sformatf("en0_%0d_qend", k), Quantum_end, 0);
        end
        cyc(0, 2'd0, 0, 0, 1, 0, 0, 0);
        chk("en0_halt_qend", Quantum_end, 0);
        idle_cyc();
        chk("en0_save_qend", Quantum_end, 1);
        chk("en0_save_proc", Proc_atual, 1);
        idle_cyc();
        chk("en0_sel_ocioso", Ocioso, 0);
        idle_cyc();
        chk("en0_ativa", Ativa_PC, 1);
        chk("en0_pc", PC_entrada, 32'h300);
        chk("en0_off", Offset, 32'h300);

        // Halt coinciding with expiry invalidates slot 3.
        cyc(1, 2'd1, 32'h500, 1, 0, 0, 1, 0);
        chk("hx_run_proc", Proc_atual, 3);
        chk("hx_run_qend", Quantum_end, 0);
        cyc(0, 2'd0, 0, 1, 0, 0, 1, 0);
        cyc(0, 2'd0, 0, 1, 1, 0, 1, 32'h3FF);
        cyc(0, 2'd0, 0, 0, 0, 0, 1, 32'h3FF);
        chk("hx_save_qend", Quantum_end, 1);
        chk("hx_save_proc", Proc_atual, 3);
        idle_cyc();
        idle_cyc();
        chk("hx_ativa", Ativa_PC, 1);
        chk("hx_pc", PC_entrada, 32'h500);
        chk("hx_off", Offset, 32'h500);
        cyc(0, 2'd0, 0, 0, 1, 0, 1, 0);
        chk("hx_run1_proc", Proc_atual, 1);
        idle_cyc();
        chk("hx_halt1_qend", Quantum_end, 1);
        idle_cyc();
        chk("hx_sel_ocioso", Ocioso, 1);
        chk("hx_sel_ativa", Ativa_PC, 0);
        idle_cyc();
        chk("hx_idle_ocioso", Ocioso, 1);

        // Reset in the middle of RUN.
        cyc(1, 2'd0, 32'h40, 0, 0, 0, 1, 0);
        idle_cyc();
        idle_cyc();
        chk("mr_ativa", Ativa_PC, 1);
        chk("mr_pc", PC_entrada, 32'h40);
        idle_cyc();
        chk("mr_run_proc", Proc_atual, 0);
        chk("mr_run_off", Offset, 32'h40);
        chk("mr_run_ocioso", Ocioso, 0);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        chk("mr_rst_ocioso", Ocioso, 1);
        chk("mr_rst_ativa", Ativa_PC, 0);
        chk("mr_rst_off", Offset, 0);
        chk("mr_rst_proc", Proc_atual, 0);
        chk("mr_rst_qend", Quantum_end, 0);
        @(negedge Clock);
        Reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle_cyc();
            chk($sformatf("mr_post%0d_ocioso", k), Ocioso, 1);
            chk($sformatf("mr_post%0d_ativa", k), Ativa_PC, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
